// File: rtl/la_pkg.sv
// ============================================================================
// Module   : la_pkg
// Brief    : Shared widths, encoder state type and word packing for LA capture
// Revision : 1.0
// ============================================================================
`default_nettype none

package la_pkg;

    localparam int LA_DATA_W = 8;
    localparam int LA_RUN_W  = 8;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RUN  = 1'b1
    } la_state_t;

    function automatic logic [LA_RUN_W+LA_DATA_W-1:0] la_pack_word(
        input logic [LA_RUN_W-1:0]  run,
        input logic [LA_DATA_W-1:0] value
    );
        return {run, value};
    endfunction

endpackage

`default_nettype wire

// File: rtl/la_input_sync.sv
// ============================================================================
// Module   : la_input_sync
// Brief    : Two-flop synchroniser for asynchronous LA inputs, free-running
// Revision : 1.0
// ============================================================================
`default_nettype none

module la_input_sync #(
    parameter int WIDTH = 8
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic [WIDTH-1:0] i_data,
    output logic [WIDTH-1:0] o_sync
);

    logic [WIDTH-1:0] r_stage1;
    logic [WIDTH-1:0] r_stage2;

    always_ff @(posedge CLK) begin
        if (!RST) begin
            r_stage1 <= '0;
            r_stage2 <= '0;
        end else begin
            r_stage1 <= i_data;
            r_stage2 <= r_stage1;
        end
    end

    assign o_sync = r_stage2;

endmodule

`default_nettype wire

// File: rtl/la_rle_encoder.sv
// ============================================================================
// Module   : la_rle_encoder
// Brief    : Run-length encoder emitting {run, value} words with a write strobe
// Revision : 1.0
// ============================================================================
`default_nettype none

module la_rle_encoder
    import la_pkg::*;
#(
    parameter int DATA_W = LA_DATA_W,
    parameter int RUN_W  = LA_RUN_W
) (
    input  logic                    CLK,
    input  logic                    RST,
    input  logic                    ENABLE,
    input  logic                    SMPL_EN,
    input  logic                    RLE_EN,
    input  logic                    FLUSH,
    input  logic [DATA_W-1:0]       LA_DATA,
    output logic [DATA_W-1:0]       LA_SYNC,
    output logic                    WR_EN,
    output logic [RUN_W+DATA_W-1:0] WR_DATA
);

    localparam int               WORD_W    = RUN_W + DATA_W;
    localparam logic [RUN_W-1:0] c_RUN_MAX = '1;

    la_state_t           r_state;
    la_state_t           w_state_nxt;
    logic [DATA_W-1:0]   r_prev;
    logic [DATA_W-1:0]   w_prev_nxt;
    logic [RUN_W-1:0]    r_run;
    logic [RUN_W-1:0]    w_run_nxt;
    logic                r_wr_en;
    logic                w_wr_en_nxt;
    logic [WORD_W-1:0]   r_wr_data;
    logic [WORD_W-1:0]   w_wr_data_nxt;
    logic [DATA_W-1:0]   w_d;
    logic [WORD_W-1:0]   w_word;
    logic                w_close_run;

    la_input_sync #(
        .WIDTH (DATA_W)
    ) u_sync (
        .CLK    (CLK),
        .RST    (RST),
        .i_data (LA_DATA),
        .o_sync (w_d)
    );

    generate
        if (DATA_W == LA_DATA_W && RUN_W == LA_RUN_W) begin : g_pack_pkg
            assign w_word = la_pack_word(r_run, r_prev);
        end else begin : g_pack_generic
            assign w_word = {r_run, r_prev};
        end
    endgenerate

    // A saturated run is closed and the same value restarts as a new run.
    assign w_close_run = !RLE_EN || (w_d != r_prev) || (r_run == c_RUN_MAX);

    always_comb begin
        w_state_nxt   = r_state;
        w_prev_nxt    = r_prev;
        w_run_nxt     = r_run;
        w_wr_en_nxt   = 1'b0;
        w_wr_data_nxt = r_wr_data;
        if (!ENABLE) begin
            w_state_nxt = IDLE;
        end else begin
            case (r_state)
                IDLE: begin
                    if (SMPL_EN) begin
                        w_prev_nxt  = w_d;
                        w_run_nxt   = '0;
                        w_state_nxt = RUN;
                    end
                end
                RUN: begin
                    if (FLUSH) begin
                        w_wr_en_nxt   = 1'b1;
                        w_wr_data_nxt = w_word;
                        w_state_nxt   = IDLE;
                    end else if (SMPL_EN) begin
                        if (w_close_run) begin
                            w_wr_en_nxt   = 1'b1;
                            w_wr_data_nxt = w_word;
                            w_prev_nxt    = w_d;
                            w_run_nxt     = '0;
                        end else begin
                            w_run_nxt = r_run + 1'b1;
                        end
                    end
                end
                default: begin
                    w_state_nxt = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (!RST) begin
            r_state   <= IDLE;
            r_prev    <= '0;
            r_run     <= '0;
            r_wr_en   <= 1'b0;
            r_wr_data <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_prev    <= w_prev_nxt;
            r_run     <= w_run_nxt;
            r_wr_en   <= w_wr_en_nxt;
            r_wr_data <= w_wr_data_nxt;
        end
    end

    assign LA_SYNC = w_d;
    assign WR_EN   = r_wr_en;
    assign WR_DATA = r_wr_data;

endmodule

`default_nettype wire

// File: tb/tb_la_rle_encoder.sv
// Bench for la_rle_encoder: directed scenarios plus randomized traffic against
// a sample-count based reference model.
`default_nettype none

module tb_la_rle_encoder;

    localparam int DW      = 8;
    localparam int RW      = 8;
    localparam int MAX_CNT = 1 << RW;

    logic          CLK     = 1'b0;
    logic          RST     = 1'b0;
    logic          ENABLE  = 1'b0;
    logic          SMPL_EN = 1'b0;
    logic          RLE_EN  = 1'b0;
    logic          FLUSH   = 1'b0;
    logic [DW-1:0] LA_DATA = '0;
    logic [DW-1:0] LA_SYNC;
    logic          WR_EN;
    logic [RW+DW-1:0] WR_DATA;

    la_rle_encoder #(.DATA_W(DW), .RUN_W(RW)) dut (
        .CLK     (CLK),
        .RST     (RST),
        .ENABLE  (ENABLE),
        .SMPL_EN (SMPL_EN),
        .RLE_EN  (RLE_EN),
        .FLUSH   (FLUSH),
        .LA_DATA (LA_DATA),
        .LA_SYNC (LA_SYNC),
        .WR_EN   (WR_EN),
        .WR_DATA (WR_DATA)
    );

    always #5 CLK = ~CLK;

    int n_checks = 0;
    int n_fail   = 0;

    // reference model: input delay line, open run as {value, sample count}
    logic [DW-1:0]    m_hist [3];
    bit               m_open;
    logic [DW-1:0]    m_val;
    int               m_cnt;
    bit               m_wr_en;
    logic [RW+DW-1:0] m_wr_data;
    logic [RW+DW-1:0] dut_words[$];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic m_emit();
        m_wr_en   = 1'b1;
        m_wr_data = {RW'(m_cnt - 1), m_val};
    endtask

    task automatic model_edge();
        logic [DW-1:0] d;
        d = m_hist[2];
        m_wr_en = 1'b0;
        if (!RST) begin
            m_hist    = '{default: '0};
            m_open    = 1'b0;
            m_val     = '0;
            m_cnt     = 0;
            m_wr_data = '0;
            return;
        end
        m_hist[2] = m_hist[1];
        m_hist[1] = LA_DATA;
        if (!ENABLE) begin
            m_open = 1'b0;
        end else if (!m_open) begin
            if (SMPL_EN) begin
                m_open = 1'b1;
                m_val  = d;
                m_cnt  = 1;
            end
        end else if (FLUSH) begin
            m_emit();
            m_open = 1'b0;
        end else if (SMPL_EN) begin
            if (!RLE_EN || d != m_val || m_cnt == MAX_CNT) begin
                m_emit();
                m_val = d;
                m_cnt = 1;
            end else begin
                m_cnt++;
            end
        end
    endtask

    task automatic step();
        @(posedge CLK);
        model_edge();
        #1;
        chk("wr_en",   32'(WR_EN),   32'(m_wr_en));
        chk("wr_data", 32'(WR_DATA), 32'(m_wr_data));
        chk("la_sync", 32'(LA_SYNC), 32'(m_hist[2]));
        if (WR_EN === 1'b1) dut_words.push_back(WR_DATA);
    endtask

    task automatic cyc(input bit s, input bit f);
        SMPL_EN = s;
        FLUSH   = f;
        step();
        SMPL_EN = 1'b0;
        FLUSH   = 1'b0;
    endtask

    task automatic settle();
        repeat (3) cyc(1'b0, 1'b0);
    endtask

    task automatic expect_words(input string tag, input logic [RW+DW-1:0] exp[$]);
        chk({tag, "_count"}, 32'(dut_words.size()), 32'(exp.size()));
        foreach (exp[i]) begin
            if (i < dut_words.size()) chk({tag, "_word"}, 32'(dut_words[i]), 32'(exp[i]));
        end
        dut_words.delete();
    endtask

    initial begin
        m_hist = '{default: '0};
        m_open = 1'b0; m_val = '0; m_cnt = 0; m_wr_en = 1'b0; m_wr_data = '0;

        // reset state
        RST = 1'b0;
        repeat (2) cyc(1'b0, 1'b0);
        chk("rst_wr_en",   32'(WR_EN),   32'h0);
        chk("rst_wr_data", 32'(WR_DATA), 32'h0);
        chk("rst_la_sync", 32'(LA_SYNC), 32'h0);
        RST = 1'b1; ENABLE = 1'b1; RLE_EN = 1'b1;

        // compression: 10 x 0x3C then 0xA5
        LA_DATA = 8'h3C; settle(); dut_words.delete();
        repeat (10) cyc(1'b1, 1'b0);
        LA_DATA = 8'hA5; cyc(1'b0, 1'b0); cyc(1'b0, 1'b0);
        cyc(1'b1, 1'b0);
        chk("cmp_strobe", 32'(WR_EN), 32'h1);
        expect_words("cmp", '{16'h093C});
        cyc(1'b0, 1'b1);
        dut_words.delete();

        // reset mid-run with run = 5
        LA_DATA = 8'h42; settle(); dut_words.delete();
        repeat (6) cyc(1'b1, 1'b0);
        RST = 1'b0; cyc(1'b1, 1'b0); RST = 1'b1;
        chk("rmr_wr_en",   32'(WR_EN),   32'h0);
        chk("rmr_wr_data", 32'(WR_DATA), 32'h0);
        chk("rmr_la_sync", 32'(LA_SYNC), 32'h0);
        settle();
        cyc(1'b1, 1'b0); cyc(1'b0, 1'b1);
        expect_words("rmr", '{16'h0042});

        // saturation: 600 samples of 0x00
        LA_DATA = 8'h00; settle(); dut_words.delete();
        repeat (600) cyc(1'b1, 1'b0);
        cyc(1'b0, 1'b1);
        expect_words("sat", '{16'hFF00, 16'hFF00, 16'h5700});

        // bypass
        RLE_EN = 1'b0; LA_DATA = 8'h11; settle(); dut_words.delete();
        cyc(1'b1, 1'b0); cyc(1'b1, 1'b0);
        LA_DATA = 8'h22; cyc(1'b0, 1'b0); cyc(1'b0, 1'b0);
        cyc(1'b1, 1'b0); cyc(1'b1, 1'b0);
        cyc(1'b0, 1'b1);
        expect_words("byp", '{16'h0011, 16'h0011, 16'h0022, 16'h0022});
        RLE_EN = 1'b1;

        // FLUSH and SMPL_EN together; follow-up proves a fresh run from IDLE
        LA_DATA = 8'h7E; settle(); dut_words.delete();
        repeat (4) cyc(1'b1, 1'b0);
        cyc(1'b1, 1'b1);
        cyc(1'b0, 1'b0);
        cyc(1'b1, 1'b0); cyc(1'b0, 1'b1);
        expect_words("coin", '{16'h037E, 16'h007E});

        // ENABLE drop during run = 7
        LA_DATA = 8'h5A; settle(); dut_words.delete();
        repeat (8) cyc(1'b1, 1'b0);
        ENABLE = 1'b0; repeat (3) cyc(1'b1, 1'b0);
        chk("ena_no_write", 32'(dut_words.size()), 32'h0);
        ENABLE = 1'b1;
        cyc(1'b1, 1'b0); cyc(1'b1, 1'b0); cyc(1'b0, 1'b1);
        expect_words("ena", '{16'h015A});

        // random traffic, busy data
        for (int i = 0; i < 3000; i++) begin
            RST     = ($urandom % 500) != 0;
            ENABLE  = ($urandom % 50) != 0;
            if ($urandom % 300 == 0) RLE_EN = ~RLE_EN;
            if ($urandom % 8 == 0) LA_DATA = ($urandom % 2) ? 8'h00 : DW'($urandom);
            SMPL_EN = ($urandom % 4) != 0;
            FLUSH   = ($urandom % 40) == 0;
            step();
        end

        // random traffic, long runs to reach saturation
        RLE_EN = 1'b1;
        for (int i = 0; i < 3000; i++) begin
            RST     = ($urandom % 2000) != 0;
            ENABLE  = ($urandom % 1500) != 0;
            if ($urandom % 600 == 0) LA_DATA = DW'($urandom);
            SMPL_EN = ($urandom % 8) != 0;
            FLUSH   = ($urandom % 1000) == 0;
            step();
        end
        RST = 1'b1; SMPL_EN = 1'b0; FLUSH = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
